// File: rtl/wb_32bit_sfifo.sv
// Synchronous 32-bit FIFO with four Wishbone slave ports: push, pop, free-space and fill-level.
// Optional WB_SFIFO_STATUS_FLAGS_EN puts empty/full flags in bits 31/30 of both status words.
module wb_32bit_sfifo #(
   parameter int unsigned ADR_W = 10
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // write-data port
   input  logic [31:0] wr_wbd_dat_i,
   input  logic        wr_wbd_we_i,
   input  logic        wr_wbd_cyc_i,
   input  logic        wr_wbd_stb_i,
   output logic        wr_wbd_ack_o,
   // write-status port
   input  logic        wr_wbs_cyc_i,
   input  logic        wr_wbs_stb_i,
   output logic        wr_wbs_ack_o,
   output logic [31:0] wr_wbs_dat_o,
   // read-data port
   input  logic        rd_wbd_cyc_i,
   input  logic        rd_wbd_stb_i,
   output logic        rd_wbd_ack_o,
   output logic [31:0] rd_wbd_dat_o,
   // read-status port
   input  logic        rd_wbs_cyc_i,
   input  logic        rd_wbs_stb_i,
   output logic        rd_wbs_ack_o,
   output logic [31:0] rd_wbs_dat_o
);

   localparam int unsigned Depth = 1 << ADR_W;
   localparam logic [ADR_W:0] FullCnt = (ADR_W+1)'(Depth);

   logic [31:0]      mem_q [Depth];
   logic [ADR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADR_W:0]   count_q, count_d;
   logic [ADR_W:0]   free_cnt;
   logic [31:0]      rd_wbd_dat_q, rd_wbd_dat_d;
   logic             wr_wbd_ack_q, wr_wbd_ack_d;
   logic             wr_wbs_ack_q, wr_wbs_ack_d;
   logic             rd_wbd_ack_q, rd_wbd_ack_d;
   logic             rd_wbs_ack_q, rd_wbs_ack_d;
   logic             full, empty, push, pop;

   // Flags come from the count before the edge, so a write on full stalls even when a pop
   // frees a slot on that same edge.
   always_comb begin
      full  = (count_q == FullCnt);
      empty = (count_q == '0);
      push  = wr_wbd_cyc_i & wr_wbd_stb_i & wr_wbd_we_i & ~wr_wbd_ack_q & ~full;
      pop   = rd_wbd_cyc_i & rd_wbd_stb_i & ~rd_wbd_ack_q & ~empty;

      wr_wbd_ack_d = wr_wbd_cyc_i & wr_wbd_stb_i & ~wr_wbd_ack_q & (~wr_wbd_we_i | ~full);
      rd_wbd_ack_d = pop;
      wr_wbs_ack_d = wr_wbs_cyc_i & wr_wbs_stb_i & ~wr_wbs_ack_q;
      rd_wbs_ack_d = rd_wbs_cyc_i & rd_wbs_stb_i & ~rd_wbs_ack_q;

      wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rd_wbd_dat_d = pop  ? mem_q[rd_ptr_q] : rd_wbd_dat_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rd_wbd_dat_q <= '0;
         wr_wbd_ack_q <= 1'b0;
         wr_wbs_ack_q <= 1'b0;
         rd_wbd_ack_q <= 1'b0;
         rd_wbs_ack_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rd_wbd_dat_q <= rd_wbd_dat_d;
         wr_wbd_ack_q <= wr_wbd_ack_d;
         wr_wbs_ack_q <= wr_wbs_ack_d;
         rd_wbd_ack_q <= rd_wbd_ack_d;
         rd_wbs_ack_q <= rd_wbs_ack_d;
      end
   end

   // Storage is not reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_wbd_dat_i;
      end
   end

   always_comb begin
      free_cnt     = FullCnt - count_q;
      wr_wbd_ack_o = wr_wbd_ack_q;
      wr_wbs_ack_o = wr_wbs_ack_q;
      rd_wbd_ack_o = rd_wbd_ack_q;
      rd_wbs_ack_o = rd_wbs_ack_q;
      rd_wbd_dat_o = rd_wbd_dat_q;
`ifdef WB_SFIFO_STATUS_FLAGS_EN
      wr_wbs_dat_o = {empty, full, 30'(free_cnt)};
      rd_wbs_dat_o = {empty, full, 30'(count_q)};
`else
      wr_wbs_dat_o = 32'(free_cnt);
      rd_wbs_dat_o = 32'(count_q);
`endif
   end

endmodule

// File: tb/tb_wb_32bit_sfifo.sv
// Directed bench for wb_32bit_sfifo (ADR_W=10); follows WB_SFIFO_STATUS_FLAGS_EN if defined.
module tb_wb_32bit_sfifo;

   localparam int Depth = 1024;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] wr_wbd_dat_i = '0;
   logic        wr_wbd_we_i = 1'b0, wr_wbd_cyc_i = 1'b0, wr_wbd_stb_i = 1'b0;
   logic        wr_wbd_ack_o;
   logic        wr_wbs_cyc_i = 1'b0, wr_wbs_stb_i = 1'b0, wr_wbs_ack_o;
   logic [31:0] wr_wbs_dat_o;
   logic        rd_wbd_cyc_i = 1'b0, rd_wbd_stb_i = 1'b0, rd_wbd_ack_o;
   logic [31:0] rd_wbd_dat_o;
   logic        rd_wbs_cyc_i = 1'b0, rd_wbs_stb_i = 1'b0, rd_wbs_ack_o;
   logic [31:0] rd_wbs_dat_o;

   int n_pass  = 0;
   int n_total = 0;

   wb_32bit_sfifo #(.ADR_W(10)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_wbd_dat_i (wr_wbd_dat_i),
      .wr_wbd_we_i  (wr_wbd_we_i),
      .wr_wbd_cyc_i (wr_wbd_cyc_i),
      .wr_wbd_stb_i (wr_wbd_stb_i),
      .wr_wbd_ack_o (wr_wbd_ack_o),
      .wr_wbs_cyc_i (wr_wbs_cyc_i),
      .wr_wbs_stb_i (wr_wbs_stb_i),
      .wr_wbs_ack_o (wr_wbs_ack_o),
      .wr_wbs_dat_o (wr_wbs_dat_o),
      .rd_wbd_cyc_i (rd_wbd_cyc_i),
      .rd_wbd_stb_i (rd_wbd_stb_i),
      .rd_wbd_ack_o (rd_wbd_ack_o),
      .rd_wbd_dat_o (rd_wbd_dat_o),
      .rd_wbs_cyc_i (rd_wbs_cyc_i),
      .rd_wbs_stb_i (rd_wbs_stb_i),
      .rd_wbs_ack_o (rd_wbs_ack_o),
      .rd_wbs_dat_o (rd_wbs_dat_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_rd(input int cnt);
      logic [31:0] v;
      v = cnt;
`ifdef WB_SFIFO_STATUS_FLAGS_EN
      v[31] = (cnt == 0);
      v[30] = (cnt == Depth);
`endif
      return v;
   endfunction

   function automatic logic [31:0] exp_wr(input int cnt);
      logic [31:0] v;
      v = Depth - cnt;
`ifdef WB_SFIFO_STATUS_FLAGS_EN
      v[31] = (cnt == 0);
      v[30] = (cnt == Depth);
`endif
      return v;
   endfunction

   // All bus tasks are entered and left 1 time unit after a rising edge.
   task automatic wb_write(input logic [31:0] dat, input logic we, input int budget,
                           output int waited);
      wr_wbd_dat_i = dat;
      wr_wbd_we_i  = we;
      wr_wbd_cyc_i = 1'b1;
      wr_wbd_stb_i = 1'b1;
      waited = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk_i); #1;
         if (wr_wbd_ack_o) begin
            waited = i;
            break;
         end
      end
      wr_wbd_cyc_i = 1'b0;
      wr_wbd_stb_i = 1'b0;
      wr_wbd_we_i  = 1'b0;
   endtask

   task automatic wb_read(input int budget, output logic [31:0] dat, output int waited);
      rd_wbd_cyc_i = 1'b1;
      rd_wbd_stb_i = 1'b1;
      waited = -1;
      dat = 'x;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk_i); #1;
         if (rd_wbd_ack_o) begin
            waited = i;
            dat = rd_wbd_dat_o;
            break;
         end
      end
      rd_wbd_cyc_i = 1'b0;
      rd_wbd_stb_i = 1'b0;
   endtask

   task automatic wb_status(input bit wr_side, output logic [31:0] dat, output logic acked);
      if (wr_side) begin
         wr_wbs_cyc_i = 1'b1; wr_wbs_stb_i = 1'b1;
      end else begin
         rd_wbs_cyc_i = 1'b1; rd_wbs_stb_i = 1'b1;
      end
      @(posedge clk_i); #1;
      acked = wr_side ? wr_wbs_ack_o : rd_wbs_ack_o;
      dat   = wr_side ? wr_wbs_dat_o : rd_wbs_dat_o;
      wr_wbs_cyc_i = 1'b0; wr_wbs_stb_i = 1'b0;
      rd_wbs_cyc_i = 1'b0; rd_wbs_stb_i = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        ack;
      int          w, acks, to_cnt;

      // Reset state
      #2;
      check_eq("rst_wr_ack", 32'(wr_wbd_ack_o), 0);
      check_eq("rst_rd_ack", 32'(rd_wbd_ack_o), 0);
      check_eq("rst_rd_dat", rd_wbd_dat_o, 0);
      check_eq("rst_rd_status", rd_wbs_dat_o, exp_rd(0));
      check_eq("rst_wr_status", wr_wbs_dat_o, exp_wr(0));
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Status ports after reset, then a stalled pop on the empty FIFO
      wb_status(1'b0, d, ack);
      check_eq("rds_ack", 32'(ack), 1);
      check_eq("rds_empty", d, exp_rd(0));
      wb_status(1'b1, d, ack);
      check_eq("wrs_ack", 32'(ack), 1);
      check_eq("wrs_empty", d, exp_wr(0));
      wb_read(20, d, w);
      check_eq("empty_pop_stall", 32'(w), 32'(-1));

      // we=0 write: acked after one cycle, nothing pushed
      @(posedge clk_i); #1;
      wb_write(32'hDEAD_BEEF, 1'b0, 10, w);
      check_eq("we0_latency", 32'(w), 1);
      check_eq("we0_no_push", rd_wbs_dat_o, exp_rd(0));

      // Four pushes, four pops in order
      for (int i = 1; i <= 4; i++) begin
         wb_write(32'hA5A5_0000 + i, 1'b1, 10, w);
      end
      wb_status(1'b0, d, ack);
      check_eq("rds_four", d, exp_rd(4));
      check_eq("wrs_four", wr_wbs_dat_o, exp_wr(4));
      for (int i = 1; i <= 4; i++) begin
         wb_read(10, d, w);
         check_eq("pop_four", d, 32'hA5A5_0000 + i);
      end
      check_eq("rds_after_pops", rd_wbs_dat_o, exp_rd(0));

      // Held request: ack never on consecutive cycles, one push per ack
      @(posedge clk_i); #1;
      wr_wbd_dat_i = 32'h1234_5678; wr_wbd_we_i = 1'b1;
      wr_wbd_cyc_i = 1'b1; wr_wbd_stb_i = 1'b1;
      acks = 0;
      repeat (4) begin
         @(posedge clk_i); #1;
         acks += int'(wr_wbd_ack_o);
      end
      wr_wbd_cyc_i = 1'b0; wr_wbd_stb_i = 1'b0; wr_wbd_we_i = 1'b0;
      check_eq("held_acks", 32'(acks), 2);
      check_eq("held_count", rd_wbs_dat_o, exp_rd(2));
      wb_read(10, d, w);
      check_eq("held_pop0", d, 32'h1234_5678);
      wb_read(10, d, w);
      check_eq("held_pop1", d, 32'h1234_5678);

      // Fill to full (pointers start at 6, so this wraps)
      for (int i = 0; i < Depth; i++) begin
         wb_write(32'hB000_0000 + i, 1'b1, 10, w);
      end
      check_eq("full_wr_status", wr_wbs_dat_o, exp_wr(Depth));
      check_eq("full_rd_status", rd_wbs_dat_o, exp_rd(Depth));
      wr_wbd_dat_i = 32'hC000_0000; wr_wbd_we_i = 1'b1;
      wr_wbd_cyc_i = 1'b1; wr_wbd_stb_i = 1'b1;
      acks = 0;
      repeat (10) begin
         @(posedge clk_i); #1;
         acks += int'(wr_wbd_ack_o);
      end
      check_eq("full_write_stall", 32'(acks), 0);
      // Pop while the write is pending; the write must wait one more edge
      wb_read(10, d, w);
      check_eq("full_pop_first", d, 32'hB000_0000);
      check_eq("full_same_edge_no_ack", 32'(wr_wbd_ack_o), 0);
      w = -1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk_i); #1;
         if (wr_wbd_ack_o) begin
            w = i;
            break;
         end
      end
      wr_wbd_cyc_i = 1'b0; wr_wbd_stb_i = 1'b0; wr_wbd_we_i = 1'b0;
      check_eq("full_write_release", 32'(w), 1);
      for (int i = 1; i <= Depth; i++) begin
         wb_read(10, d, w);
         check_eq("wrap_order", d, (i == Depth) ? 32'hC000_0000 : 32'hB000_0000 + i);
      end
      check_eq("wrap_drained", rd_wbs_dat_o, exp_rd(0));

      // Concurrent streaming with random gaps
      to_cnt = 0;
      fork
         begin
            int ww;
            for (int i = 0; i < 5000; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk_i);
               @(posedge clk_i); #1;
               wb_write(32'hD000_0000 + i, 1'b1, 2000, ww);
               if (ww < 0) to_cnt++;
            end
         end
         begin
            int          rw;
            logic [31:0] rd;
            for (int i = 0; i < 5000; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk_i);
               @(posedge clk_i); #1;
               wb_read(2000, rd, rw);
               if (rw < 0) to_cnt++;
               check_eq("stream_data", rd, 32'hD000_0000 + i);
            end
         end
      join
      check_eq("stream_timeouts", 32'(to_cnt), 0);
      @(posedge clk_i); #1;
      check_eq("stream_final_count", rd_wbs_dat_o, exp_rd(0));

      // Reset during a write with three words stored
      for (int i = 0; i < 3; i++) begin
         wb_write(32'hE000_0000 + i, 1'b1, 10, w);
      end
      @(posedge clk_i); #1;
      wr_wbd_dat_i = 32'hE000_0003; wr_wbd_we_i = 1'b1;
      wr_wbd_cyc_i = 1'b1; wr_wbd_stb_i = 1'b1;
      rd_wbs_cyc_i = 1'b1; rd_wbs_stb_i = 1'b1;
      @(posedge clk_i); #1;
      check_eq("prerst_wr_ack", 32'(wr_wbd_ack_o), 1);
      rst_i = 1'b0;
      #1;
      check_eq("rst_async_wr_ack", 32'(wr_wbd_ack_o), 0);
      check_eq("rst_async_rds_ack", 32'(rd_wbs_ack_o), 0);
      check_eq("rst_async_count", rd_wbs_dat_o, exp_rd(0));
      wr_wbd_cyc_i = 1'b0; wr_wbd_stb_i = 1'b0; wr_wbd_we_i = 1'b0;
      rd_wbs_cyc_i = 1'b0; rd_wbs_stb_i = 1'b0;
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;
      check_eq("postrst_rd_status", rd_wbs_dat_o, exp_rd(0));
      check_eq("postrst_wr_status", wr_wbs_dat_o, exp_wr(0));
      check_eq("postrst_rd_dat", rd_wbd_dat_o, 0);
      wb_read(10, d, w);
      check_eq("postrst_pop_stall", 32'(w), 32'(-1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_32bit_sfifo.md
WB_32BIT_SFIFO -- requirements
Module: wb_32bit_sfifo

Interface
REQ-001 Parameter: ADR_W, default 10, log2 of FIFO depth in 32-bit words (depth = 2^ADR_W).
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 wr_wbd_dat_i  in  32  write-data port: word to push.
REQ-005 wr_wbd_we_i / wr_wbd_cyc_i / wr_wbd_stb_i  in  1 each  write-data port Wishbone strobes.
REQ-006 wr_wbd_ack_o  out  1  write-data port acknowledge.
REQ-007 wr_wbs_cyc_i / wr_wbs_stb_i  in  1 each; wr_wbs_ack_o  out  1; wr_wbs_dat_o  out  32  write-status port (free space).
REQ-008 rd_wbd_cyc_i / rd_wbd_stb_i  in  1 each; rd_wbd_ack_o  out  1; rd_wbd_dat_o  out  32  read-data port (pop).
REQ-009 rd_wbs_cyc_i / rd_wbs_stb_i  in  1 each; rd_wbs_ack_o  out  1; rd_wbs_dat_o  out  32  read-status port (fill level).

Function
REQ-010 Storage: 2^ADR_W x 32 array, ADR_W-bit write/read pointers, ADR_W+1-bit count; pointers wrap from 2^ADR_W-1 to 0.
REQ-011 All four ports use registered single-cycle ack: ack_o <= cyc & stb & ~ack_o & ready; never asserted two consecutive cycles; minimum 2 cycles per access.
REQ-012 Write-data: ready = ~full; with we=1 the push (mem[wr_ptr] <= dat_i, wr_ptr+1) occurs in the same edge that raises ack.
REQ-013 Write-data with we=0: acked per REQ-011 (ready=1), no push.
REQ-014 Write-data while full: no ack, no push; master stalls until a pop frees a slot.
REQ-015 Read-data: ready = ~empty; on the ack-raising edge rd_wbd_dat_o <= mem[rd_ptr], rd_ptr+1; dat_o valid while ack high and held until next pop.
REQ-016 Read-data while empty: no ack, no pop; master stalls until a push.
REQ-017 Status ports: always ready; wr_wbs_dat_o = 2^ADR_W - count, rd_wbs_dat_o = count, zero-extended to 32 bits, combinational from current count.
REQ-018 Simultaneous push and pop on the same edge: both performed, count unchanged; full/empty evaluated from count before the edge (write on full is stalled even if a pop occurs that edge).
REQ-019 full = (count == 2^ADR_W); empty = (count == 0).
REQ-020 No err/rty generation; cyc/stb deassertion before ack aborts the access with no state change.

Reset
REQ-021 rst_i low asynchronously clears wr_ptr, rd_ptr, count, all four ack_o and rd_wbd_dat_o to 0; array contents not reset.
REQ-022 Reset asserted mid-access aborts it; after release FIFO is empty (rd_wbs_dat_o = 0, wr_wbs_dat_o = 2^ADR_W).

Configuration
REQ-023 Macro WB_SFIFO_STATUS_FLAGS_EN defined: both status words carry bit31 = empty, bit30 = full, count fields in low bits unchanged (ADR_W <= 29 required).
REQ-024 Macro not defined: status bits above bit ADR_W are 0.

Verification
REQ-025 After reset, read both status ports -> rd_wbs_dat_o = 0, wr_wbs_dat_o = 1024 (ADR_W=10); read-data access stalls with no ack for 20 cycles.
REQ-026 Push 0xA5A5_0001..0xA5A5_0004, pop four -> same values in order; rd status 4 after pushes, 0 after pops.
REQ-027 Fill with 1024 words -> wr status 0 (flags build: bit30=1); 1025th write unacked until one pop, then acked and data order preserved across pointer wrap.
REQ-028 Concurrent writer and reader streaming 5000 words with random cyc/stb gaps -> data sequence intact, final count 0.
REQ-029 Assert rst_i low during a pending write with 3 words stored -> acks drop immediately, rd status 0 after release, next pop stalls.
REQ-030 Write access with we=0 -> ack after one cycle, rd status unchanged.
